// File: rtl/pic_host_bus_master_pkg.sv
// Shared types for the 8259A host bus master: FSM state encoding, strobe idle level
// and the counter-sizing helper.
package pic_host_bus_master_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_STROBE,
    ST_HOLD,
    ST_ACK1,
    ST_GAP,
    ST_ACK2,
    ST_RECOVER
  } state_t;

  localparam logic STROBE_IDLE = 1'b1;

  function automatic int max_of(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/pic_int_sync.sv
// Reset-to-0 multi-flop synchronizer for the PIC INT line.
// Latency STAGES cycles; no backpressure.
module pic_int_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic async_in,
  output logic sync_out
);

  logic [STAGES-1:0] chain;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) chain <= '0;
    else        chain <= {chain[STAGES-2:0], async_in};
  end

  assign sync_out = chain[STAGES-1];

endmodule

// File: rtl/pic_host_bus_master.sv
// CPU-side 8259A bus master: timed CS/RD/WR/A0 cycles and 8086-mode two-pulse INTA.
// All bus outputs are registered from the next-state decode so they never glitch.
module pic_host_bus_master
  import pic_host_bus_master_pkg::*;
#(
  parameter int SETUP_CYC   = 1,
  parameter int PULSE_CYC   = 3,
  parameter int HOLD_CYC    = 1,
  parameter int GAP_CYC     = 2,
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic       cmd_write,
  input  logic       cmd_a0,
  input  logic [7:0] cmd_wdata,
  output logic       rsp_valid,
  output logic [7:0] rsp_rdata,
  input  logic       ack_enable,
  output logic       vec_valid,
  output logic [7:0] vec_data,
  output logic       busy,
  input  logic       INT,
  output logic       CS,
  output logic       RD,
  output logic       WR,
  output logic       A0,
  output logic       INTA,
  output logic [7:0] data_out,
  output logic       data_oe,
  input  logic [7:0] data_in
);

  localparam int MAX_CYC = max_of(max_of(max_of(SETUP_CYC, PULSE_CYC), max_of(HOLD_CYC, GAP_CYC)),
                                  SYNC_STAGES + 1);
  localparam int CW = $clog2(MAX_CYC + 1);
  typedef logic [CW-1:0] cnt_t;

  // Reload values are length-1: a state lasts until the counter reads zero.
  localparam cnt_t SETUP_LD   = cnt_t'(SETUP_CYC - 1);
  localparam cnt_t PULSE_LD   = cnt_t'(PULSE_CYC - 1);
  localparam cnt_t HOLD_LD    = cnt_t'(HOLD_CYC - 1);
  localparam cnt_t GAP_LD     = cnt_t'(GAP_CYC - 1);
  localparam cnt_t RECOVER_LD = cnt_t'(SYNC_STAGES);

  state_t     state, state_nxt;
  cnt_t       cnt, cnt_nxt;
  logic       write_q, write_nxt;
  logic       a0_q, a0_nxt;
  logic [7:0] wdata_q, wdata_nxt;
  logic       int_sync, ack_start, rd_sample, vec_sample, bus_nxt;

  pic_int_sync #(.STAGES(SYNC_STAGES)) u_int_sync (
    .clk      (clk),
    .rst_n    (rst_n),
    .async_in (INT),
    .sync_out (int_sync)
  );

  assign ack_start = (state == ST_IDLE) & ack_enable & int_sync;
  assign cmd_ready = (state == ST_IDLE) & ~ack_start;
  assign bus_nxt   = (state_nxt == ST_SETUP) | (state_nxt == ST_STROBE) | (state_nxt == ST_HOLD);

  always_comb begin
    state_nxt  = state;
    cnt_nxt    = (cnt == '0) ? cnt : cnt - cnt_t'(1);
    write_nxt  = write_q;
    a0_nxt     = a0_q;
    wdata_nxt  = wdata_q;
    rd_sample  = 1'b0;
    vec_sample = 1'b0;
    case (state)
      ST_IDLE: begin
        if (ack_start) begin
          state_nxt = ST_ACK1;
          cnt_nxt   = PULSE_LD;
        end else if (cmd_valid) begin
          write_nxt = cmd_write;
          a0_nxt    = cmd_a0;
          wdata_nxt = cmd_wdata;
          if (SETUP_CYC > 0) begin
            state_nxt = ST_SETUP;
            cnt_nxt   = SETUP_LD;
          end else begin
            state_nxt = ST_STROBE;
            cnt_nxt   = PULSE_LD;
          end
        end
      end
      ST_SETUP: if (cnt == '0) begin
        state_nxt = ST_STROBE;
        cnt_nxt   = PULSE_LD;
      end
      ST_STROBE: if (cnt == '0) begin
        rd_sample = ~write_q;
        if (HOLD_CYC > 0) begin
          state_nxt = ST_HOLD;
          cnt_nxt   = HOLD_LD;
        end else begin
          state_nxt = ST_IDLE;
        end
      end
      ST_HOLD:    if (cnt == '0) state_nxt = ST_IDLE;
      ST_ACK1: if (cnt == '0) begin
        state_nxt = ST_GAP;
        cnt_nxt   = GAP_LD;
      end
      ST_GAP: if (cnt == '0) begin
        state_nxt = ST_ACK2;
        cnt_nxt   = PULSE_LD;
      end
      ST_ACK2: if (cnt == '0) begin
        vec_sample = 1'b1;
        state_nxt  = ST_RECOVER;
        cnt_nxt    = RECOVER_LD;
      end
      ST_RECOVER: if (cnt == '0) state_nxt = ST_IDLE;
      default:    state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      write_q   <= 1'b0;
      a0_q      <= 1'b0;
      wdata_q   <= '0;
      busy      <= 1'b0;
      CS        <= STROBE_IDLE;
      RD        <= STROBE_IDLE;
      WR        <= STROBE_IDLE;
      INTA      <= STROBE_IDLE;
      A0        <= 1'b0;
      data_oe   <= 1'b0;
      data_out  <= '0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      vec_valid <= 1'b0;
      vec_data  <= '0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      write_q   <= write_nxt;
      a0_q      <= a0_nxt;
      wdata_q   <= wdata_nxt;
      busy      <= (state_nxt != ST_IDLE);
      CS        <= ~bus_nxt;
      RD        <= ~((state_nxt == ST_STROBE) & ~write_nxt);
      WR        <= ~((state_nxt == ST_STROBE) & write_nxt);
      INTA      <= ~((state_nxt == ST_ACK1) | (state_nxt == ST_ACK2));
      A0        <= bus_nxt & a0_nxt;
      data_oe   <= bus_nxt & write_nxt;
      data_out  <= (bus_nxt & write_nxt) ? wdata_nxt : 8'h00;
      rsp_valid <= rd_sample;
      vec_valid <= vec_sample;
      if (rd_sample)  rsp_rdata <= data_in;
      if (vec_sample) vec_data  <= data_in;
    end
  end

endmodule
